ram_slot_arbiter: RTL and testbench

Shares the single per-PHI2-cycle SDRAM access slot of the RAM controller between two requesters. The requesters are the host CPU bus and a secondary DMA/loader port. The CPU always wins its own cycle. DMA uses idle slots through a REQ/ACK handshake, and a starvation flag reports when DMA is being locked out. The block sits between the bus decode/DMA logic and the RAM controller's RDCMD/WRCMD/A/WRD/RDD interface.

---
 rtl/ram_arb_pkg.sv | 17 +
 rtl/phi2_edge_sync.sv | 28 ++
 rtl/ram_slot_arbiter.sv | 158 +++++++++++++++
 tb/tb_ram_slot_arbiter.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and default sizing for the RAM slot arbiter.
// Grant encoding and slot timing defaults live here so the top and bench agree.
package ram_arb_pkg;

  localparam int AW_DEFAULT           = 24;
  localparam int DW_DEFAULT           = 8;
  localparam int SLOT_LEN_DEFAULT     = 8;
  localparam int CAP_CYC_DEFAULT      = 5;
  localparam int STARVE_LIMIT_DEFAULT = 16;

  typedef enum logic [1:0] {
    G_NONE = 2'd0,
    G_CPU  = 2'd1,
    G_DMA  = 2'd2
  } grant_t;

endpackage

// File: rtl/phi2_edge_sync.sv
// Brings the asynchronous PHI2 into the C8M domain and emits one-cycle
// rise/fall pulses. The first two flops synchronize; the third is edge history.
module phi2_edge_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic phi2_i,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= phi2_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/ram_slot_arbiter.sv
// Shares the single per-PHI2 SDRAM slot between the CPU bus (always wins)
// and a DMA port using idle slots via REQ/ACK, with a sticky starvation flag.
module ram_slot_arbiter
  import ram_arb_pkg::*;
#(
  parameter int AW           = AW_DEFAULT,
  parameter int DW           = DW_DEFAULT,
  parameter int SLOT_LEN     = SLOT_LEN_DEFAULT,
  parameter int CAP_CYC      = CAP_CYC_DEFAULT,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic          C8M,
  input  logic          RESET,
  input  logic          PHI2,
  input  logic          CPU_SEL,
  input  logic          CPU_WE,
  input  logic [AW-1:0] CPU_A,
  input  logic [DW-1:0] CPU_WRD,
  input  logic          DMA_REQ,
  input  logic          DMA_WE,
  input  logic [AW-1:0] DMA_A,
  input  logic [DW-1:0] DMA_WRD,
  output logic          DMA_ACK,
  output logic [DW-1:0] DMA_RDD,
  output logic          DMA_STARVED,
  output logic          RDCMD,
  output logic          WRCMD,
  output logic [AW-1:0] A,
  output logic [DW-1:0] WRD,
  input  logic [DW-1:0] RDD
);

  localparam int SCW = $clog2(SLOT_LEN);
  localparam int WCW = $clog2(STARVE_LIMIT + 1);

  logic phi2_rise, phi2_fall;

  phi2_edge_sync u_sync (
    .clk_i  (C8M),
    .rst_i  (RESET),
    .phi2_i (PHI2),
    .rise_o (phi2_rise),
    .fall_o (phi2_fall)
  );

  grant_t         grant_q, grant_d;
  logic           busy_q, busy_d;
  logic           inflight_q, inflight_d;
  logic           dma_wr_q, dma_wr_d;
  logic [SCW-1:0] sc_q, sc_d;
  logic [WCW-1:0] wait_q, wait_d;
  logic           starved_q, starved_d;
  logic           rdcmd_q, rdcmd_d;
  logic           wrcmd_q, wrcmd_d;
  logic [AW-1:0]  a_q, a_d;
  logic           ack_q, ack_d;
  logic [DW-1:0]  rdd_q, rdd_d;
  logic           capture;

  always_comb begin
    grant_d    = grant_q;
    busy_d     = busy_q;
    inflight_d = inflight_q;
    dma_wr_d   = dma_wr_q;
    sc_d       = sc_q;
    wait_d     = wait_q;
    starved_d  = starved_q;
    rdcmd_d    = rdcmd_q;
    wrcmd_d    = wrcmd_q;
    a_d        = a_q;
    ack_d      = 1'b0;
    rdd_d      = rdd_q;

    capture = inflight_q && (sc_q == SCW'(CAP_CYC));
    if (capture) begin
      ack_d      = 1'b1;
      inflight_d = 1'b0;
      busy_d     = 1'b0;
      if (!dma_wr_q) rdd_d = RDD;
    end

    if (phi2_rise) begin
      if (CPU_SEL) begin
        grant_d = G_CPU;
        a_d     = CPU_A;
        wrcmd_d = CPU_WE;
        rdcmd_d = !CPU_WE;
        // A pending, grantable DMA request that lost to the CPU counts as a miss
        if (DMA_REQ && !busy_q) begin
          if (wait_q < WCW'(STARVE_LIMIT)) wait_d = wait_q + WCW'(1);
          if (wait_d == WCW'(STARVE_LIMIT)) starved_d = 1'b1;
        end
      end else if (DMA_REQ && !busy_q) begin
        grant_d   = G_DMA;
        a_d       = DMA_A;
        wrcmd_d   = DMA_WE;
        rdcmd_d   = !DMA_WE;
        busy_d    = 1'b1;
        dma_wr_d  = DMA_WE;
        wait_d    = '0;
        starved_d = 1'b0;
      end else begin
        grant_d = G_NONE;
        rdcmd_d = 1'b0;
        wrcmd_d = 1'b0;
      end
      if (!DMA_REQ) wait_d = '0;
    end

    // Every PHI2 fall (even an early one) restarts the slot timeline
    if (phi2_fall) begin
      sc_d       = SCW'(1);
      inflight_d = (grant_q == G_DMA);
    end else if (sc_q != '0) begin
      sc_d = (sc_q == SCW'(SLOT_LEN - 1)) ? '0 : sc_q + SCW'(1);
    end
  end

  always_ff @(posedge C8M) begin
    if (RESET) begin
      grant_q    <= G_NONE;
      busy_q     <= 1'b0;
      inflight_q <= 1'b0;
      dma_wr_q   <= 1'b0;
      sc_q       <= '0;
      wait_q     <= '0;
      starved_q  <= 1'b0;
      rdcmd_q    <= 1'b0;
      wrcmd_q    <= 1'b0;
      a_q        <= '0;
      ack_q      <= 1'b0;
      rdd_q      <= '0;
    end else begin
      grant_q    <= grant_d;
      busy_q     <= busy_d;
      inflight_q <= inflight_d;
      dma_wr_q   <= dma_wr_d;
      sc_q       <= sc_d;
      wait_q     <= wait_d;
      starved_q  <= starved_d;
      rdcmd_q    <= rdcmd_d;
      wrcmd_q    <= wrcmd_d;
      a_q        <= a_d;
      ack_q      <= ack_d;
      rdd_q      <= rdd_d;
    end
  end

  // WRD stays combinational: the RAM controller latches it at PHI2 fall
  assign WRD         = (grant_q == G_CPU) ? CPU_WRD : DMA_WRD;
  assign RDCMD       = rdcmd_q;
  assign WRCMD       = wrcmd_q;
  assign A           = a_q;
  assign DMA_ACK     = ack_q;
  assign DMA_RDD     = rdd_q;
  assign DMA_STARVED = starved_q;

endmodule

// File: tb/tb_ram_slot_arbiter.sv
// Directed bench for ram_slot_arbiter: a vector table of single slots plus
// hand-written starvation, PHI2-stop and mid-transfer reset sequences.
module tb_ram_slot_arbiter;

  logic        C8M = 1'b0;
  logic        RESET, PHI2, CPU_SEL, CPU_WE, DMA_REQ, DMA_WE;
  logic [23:0] CPU_A, DMA_A, A;
  logic [7:0]  CPU_WRD, DMA_WRD, WRD, RDD, DMA_RDD;
  logic        DMA_ACK, DMA_STARVED, RDCMD, WRCMD;

  int checks = 0;
  int errors = 0;
  int ack_cnt = 0;
  int ack_base;

  ram_slot_arbiter dut (
    .C8M(C8M), .RESET(RESET), .PHI2(PHI2),
    .CPU_SEL(CPU_SEL), .CPU_WE(CPU_WE), .CPU_A(CPU_A), .CPU_WRD(CPU_WRD),
    .DMA_REQ(DMA_REQ), .DMA_WE(DMA_WE), .DMA_A(DMA_A), .DMA_WRD(DMA_WRD),
    .DMA_ACK(DMA_ACK), .DMA_RDD(DMA_RDD), .DMA_STARVED(DMA_STARVED),
    .RDCMD(RDCMD), .WRCMD(WRCMD), .A(A), .WRD(WRD), .RDD(RDD)
  );

  always #5 C8M = ~C8M;

  always @(posedge C8M) if (DMA_ACK === 1'b1) ack_cnt <= ack_cnt + 1;

  typedef struct {
    logic        cpu_sel, cpu_we;
    logic [23:0] cpu_a;
    logic [7:0]  cpu_wrd;
    logic        dma_req, dma_we;
    logic [23:0] dma_a;
    logic [7:0]  dma_wrd, rdd;
    logic        exp_rdcmd, exp_wrcmd;
    logic [23:0] exp_a;
    logic [7:0]  exp_wrd;
    int          exp_acks;
    logic [7:0]  exp_rdd;
  } vec_t;

  vec_t vec [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic phi2_high(input int n);
    PHI2 = 1'b1;
    repeat (n) @(negedge C8M);
  endtask

  task automatic phi2_low(input int n);
    PHI2 = 1'b0;
    repeat (n) @(negedge C8M);
  endtask

  initial begin
    vec[0] = '{1, 0, 24'h123456, 8'h44, 0, 0, 24'h000000, 8'h00, 8'h00,
               1, 0, 24'h123456, 8'h44, 0, 8'h00};
    vec[1] = '{0, 0, 24'h000000, 8'h00, 1, 0, 24'h00ABCD, 8'h10, 8'h5A,
               1, 0, 24'h00ABCD, 8'h10, 1, 8'h5A};
    vec[2] = '{0, 0, 24'h000000, 8'h00, 1, 1, 24'h001000, 8'hC3, 8'h77,
               0, 1, 24'h001000, 8'hC3, 1, 8'h5A};
    vec[3] = '{0, 0, 24'h000000, 8'h00, 0, 0, 24'h000000, 8'h11, 8'h66,
               0, 0, 24'h001000, 8'h11, 0, 8'h5A};
    vec[4] = '{1, 1, 24'h0F0F0F, 8'h99, 1, 0, 24'h000777, 8'h00, 8'h55,
               0, 1, 24'h0F0F0F, 8'h99, 0, 8'h5A};
    vec[5] = '{0, 0, 24'h000000, 8'h00, 1, 0, 24'h000042, 8'h22, 8'hE1,
               1, 0, 24'h000042, 8'h22, 1, 8'hE1};

    RESET = 1'b1; PHI2 = 1'b0; CPU_SEL = 0; CPU_WE = 0; CPU_A = '0; CPU_WRD = '0;
    DMA_REQ = 0; DMA_WE = 0; DMA_A = '0; DMA_WRD = '0; RDD = '0;

    // Reset held while PHI2 toggles
    repeat (3) begin
      @(negedge C8M);
      PHI2 = ~PHI2;
    end
    @(negedge C8M);
    PHI2 = 1'b0;
    RESET = 1'b0;
    repeat (4) @(negedge C8M);
    chk("reset_rdcmd", RDCMD, 0);
    chk("reset_wrcmd", WRCMD, 0);
    chk("reset_a", A, 0);
    chk("reset_rdd", DMA_RDD, 0);
    chk("reset_starved", DMA_STARVED, 0);
    chk("reset_ack", ack_cnt, 0);
    chk("reset_sc", dut.sc_q, 0);

    for (int i = 0; i < 6; i++) begin
      CPU_SEL = vec[i].cpu_sel; CPU_WE = vec[i].cpu_we;
      CPU_A = vec[i].cpu_a; CPU_WRD = vec[i].cpu_wrd;
      DMA_REQ = vec[i].dma_req; DMA_WE = vec[i].dma_we;
      DMA_A = vec[i].dma_a; DMA_WRD = vec[i].dma_wrd; RDD = vec[i].rdd;
      ack_base = ack_cnt;
      phi2_high(6);
      chk($sformatf("v%0d_rdcmd", i), RDCMD, vec[i].exp_rdcmd);
      chk($sformatf("v%0d_wrcmd", i), WRCMD, vec[i].exp_wrcmd);
      chk($sformatf("v%0d_a", i), A, vec[i].exp_a);
      chk($sformatf("v%0d_wrd", i), WRD, vec[i].exp_wrd);
      chk($sformatf("v%0d_early_ack", i), ack_cnt - ack_base, 0);
      phi2_low(10);
      chk($sformatf("v%0d_acks", i), ack_cnt - ack_base, vec[i].exp_acks);
      chk($sformatf("v%0d_dma_rdd", i), DMA_RDD, vec[i].exp_rdd);
      chk($sformatf("v%0d_starved", i), DMA_STARVED, 0);
    end

    // Starvation: CPU wins 16 consecutive slots against a pending DMA request
    ack_base = ack_cnt;
    for (int i = 0; i < 16; i++) begin
      CPU_SEL = 1; CPU_WE = 0; CPU_A = 24'(i + 24'h200); DMA_REQ = 1; DMA_WE = 0;
      DMA_A = 24'h005555; RDD = 8'h81;
      phi2_high(6);
      if (i == 15) begin
        chk("starve_set", DMA_STARVED, 1);
        chk("starve_cpu_a", A, 24'h20F);
      end
      phi2_low(10);
      if (i == 14) chk("starve_not_yet", DMA_STARVED, 0);
    end
    chk("starve_no_ack", ack_cnt - ack_base, 0);
    CPU_SEL = 0;
    phi2_high(6);
    chk("starve_clear", DMA_STARVED, 0);
    chk("starve_dma_a", A, 24'h005555);
    chk("starve_dma_rdcmd", RDCMD, 1);
    phi2_low(10);
    chk("starve_dma_ack", ack_cnt - ack_base, 1);
    chk("starve_dma_rdd", DMA_RDD, 8'h81);

    // PHI2 stopped: outputs hold, nothing new is acked
    DMA_REQ = 0;
    ack_base = ack_cnt;
    phi2_low(30);
    chk("stop_ack", ack_cnt - ack_base, 0);
    chk("stop_rdcmd_hold", RDCMD, 1);
    chk("stop_a_hold", A, 24'h005555);

    // Reset while a DMA read is in flight (slot counter at 3)
    DMA_REQ = 1; DMA_WE = 0; DMA_A = 24'h003333; RDD = 8'h3C;
    ack_base = ack_cnt;
    phi2_high(6);
    chk("rst_mid_grant_a", A, 24'h003333);
    PHI2 = 1'b0;
    repeat (5) @(negedge C8M);
    chk("rst_mid_sc", dut.sc_q, 3);
    RESET = 1'b1; DMA_REQ = 0;
    repeat (3) @(negedge C8M);
    RESET = 1'b0;
    repeat (12) @(negedge C8M);
    chk("rst_mid_no_ack", ack_cnt - ack_base, 0);
    chk("rst_mid_rdcmd", RDCMD, 0);
    chk("rst_mid_a", A, 0);
    chk("rst_mid_rdd", DMA_RDD, 0);

    // Re-request after reset is served normally
    DMA_REQ = 1;
    phi2_high(6);
    chk("rereq_a", A, 24'h003333);
    chk("rereq_rdcmd", RDCMD, 1);
    phi2_low(10);
    chk("rereq_ack", ack_cnt - ack_base, 1);
    chk("rereq_rdd", DMA_RDD, 8'h3C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
